// File: rtl/uart_pkg.sv
// Shared UART package: FIFO sizing defaults and the byte type used by the TX/RX datapaths.
package uart_pkg;

  localparam int UART_FIFO_DEPTH_LOG2 = 4;
  localparam int UART_TX_LOW_WATER    = 4;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic FIFO storage: synchronous write, asynchronous (combinational) read.
// Contents are intentionally not reset.
module uart_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Capture the written word on the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte FIFO between the CPU register interface and the UART serializer.
// Pointer and level control live here; storage is the shared uart_fifo_mem.
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int LOW_WATER  = UART_TX_LOW_WATER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  ovf_clear,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  irq_lowwater,
  output logic                  idle,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_LOW  = LOW_WATER[DEPTH_LOG2:0];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  overflow_q;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;
  uart_byte_t            head;

  // Status is decoded from the registered level only (idle additionally sees tx_busy).
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign tx_valid     = !empty;
  assign irq_lowwater = (level_q <= LVL_LOW);
  assign idle         = empty && !tx_busy;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign tx_data      = head;

  // Pop mirrors the transmitter's load rule; full is the start-of-cycle value,
  // so a write while full is dropped even when a pop frees a slot this cycle.
  assign push    = wr_en && !full && !flush;
  assign pop     = tx_valid && !tx_busy && !flush;
  assign ovf_set = wr_en && full && !flush;

  // Pointers and level counter; flush returns everything to the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow; a new dropped write beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow_q <= 1'b0;
    else if (ovf_set)   overflow_q <= 1'b1;
    else if (ovf_clear) overflow_q <= 1'b0;
  end

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (8)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       ovf_clear;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       irq_lowwater;
  logic       idle;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  bit         mov;

  uart_tx_fifo #(.DEPTH_LOG2(4), .LOW_WATER(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .flush        (flush),
    .ovf_clear    (ovf_clear),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .irq_lowwater (irq_lowwater),
    .idle         (idle),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue with the FIFO's accept/drop/flush rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      bit was_full;
      was_full = (mq.size() == DEPTH);
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && !tx_busy) sent.push_back(mq.pop_front());
        if (wr_en && !was_full) mq.push_back(wr_data);
      end
      if (wr_en && was_full && !flush) mov = 1'b1;
      else if (ovf_clear)              mov = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model, away from the clock edge.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("level", level, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("tx_valid", tx_valid, n != 0);
    chk("irq_lowwater", irq_lowwater, n <= LW);
    chk("overflow", overflow, mov);
    chk("idle", idle, (n == 0) && !tx_busy);
    if (n != 0) chk("tx_data", tx_data, mq[0]);
  end

  task automatic step(input bit w, input logic [7:0] d, input bit b, input bit f, input bit oc);
    wr_en = w; wr_data = d; tx_busy = b; flush = f; ovf_clear = oc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_data = 0; tx_busy = 0; flush = 0; ovf_clear = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_irq", irq_lowwater, 1);
    chk("rst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single byte, one-cycle latency, then popped.
    sent.delete();
    step(1, 8'h41, 0, 0, 0);
    chk("t1_valid", tx_valid, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_level", level, 1);
    step(0, 8'h00, 0, 0, 0);
    chk("t1_level0", level, 0);
    chk("t1_empty", empty, 1);
    chk("t1_sent", sent.size() == 1 && sent[0] == 8'h41, 1);

    // 2: fill while busy, overflow on 17th write, ordered drain.
    sent.delete();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0, 0);
    chk("t2_full", full, 1);
    chk("t2_level", level, 16);
    chk("t2_irq", irq_lowwater, 0);
    step(1, 8'hFF, 1, 0, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_level16", level, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
    end
    chk("t2_count", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("t2_order", sent[i], 8'(i));

    // 3: overflow clear vs. set priority, low-water threshold crossing.
    for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    chk("t3_ovf_clr", overflow, 0);
    step(1, 8'hEE, 1, 0, 1);
    chk("t3_ovf_set_wins", overflow, 1);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
    end
    chk("t3_level5", level, 5);
    chk("t3_irq_lo", irq_lowwater, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t3_level4", level, 4);
    chk("t3_irq_hi", irq_lowwater, 1);
    repeat (5) step(0, 8'h00, 0, 0, 0);
    chk("t3_empty", empty, 1);

    // 4: simultaneous push/pop at level 5, then 40 streamed bytes across the wrap.
    for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i), 1, 0, 0);
    sent.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    exp_q.push_back(8'hB0);
    step(1, 8'hB0, 0, 0, 0);
    chk("t4_level", level, 5);
    chk("t4_head", tx_data, 8'hA1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      exp_q.push_back(r);
      step(1, r, 0, 0, 0);
    end
    chk("t4_level_stream", level, 5);
    repeat (6) step(0, 8'h00, 0, 0, 0);
    chk("t4_count", sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) chk("t4_order", sent[i], exp_q[i]);

    // 5: flush with concurrent write keeps overflow, next byte is the new one.
    for (int i = 0; i < 8; i++) step(1, 8'h60 + 8'(i), 1, 0, 0);
    step(1, 8'h77, 1, 1, 0);
    chk("t5_level", level, 0);
    chk("t5_empty", empty, 1);
    chk("t5_valid", tx_valid, 0);
    chk("t5_ovf", overflow, 1);
    step(1, 8'h55, 1, 0, 0);
    chk("t5_data", tx_data, 8'h55);
    chk("t5_valid1", tx_valid, 1);
    sent.delete();
    step(0, 8'h00, 0, 0, 0);
    chk("t5_sent", sent.size() == 1 && sent[0] == 8'h55, 1);

    // 6: asynchronous reset mid-stream.
    for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 1, 0, 0);
    wr_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_valid", tx_valid, 0);
    chk("t6_irq", irq_lowwater, 1);
    chk("t6_ovf", overflow, 0);
    chk("t6_idle_busy", idle, 0);
    tx_busy = 0;
    #1;
    chk("t6_idle", idle, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic with alternating transmitter load to visit full and empty.
    for (int blk = 0; blk < 8; blk++) begin
      int busy_pct;
      busy_pct = blk[0] ? 85 : 25;
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(0, 99) < 60, 8'($urandom),
             $urandom_range(0, 99) < busy_pct,
             $urandom_range(0, 79) == 0,
             $urandom_range(0, 99) < 3);
      end
    end
    step(0, 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the CPU-side register interface and the UART transmitter's serializer stage.
- Accepts single-cycle byte writes, buffers up to 2^DEPTH_LOG2 bytes.
- Presents them to the transmitter via tx_data/tx_valid, gated by the transmitter's tx_busy.
- Provides level, full/empty, sticky overflow, low-water interrupt and idle status for the register file.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 2..8
LOW_WATER, 4, irq_lowwater asserts when level <= LOW_WATER; legal range 0..2^DEPTH_LOG2-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_data  in  8  byte to enqueue
wr_en  in  1  single-cycle write strobe
flush  in  1  discard all buffered bytes
ovf_clear  in  1  clear sticky overflow flag
full  out  1  level == 2^DEPTH_LOG2
empty  out  1  level == 0
level  out  DEPTH_LOG2+1  number of buffered bytes
overflow  out  1  sticky: a write was dropped
irq_lowwater  out  1  level <= LOW_WATER
idle  out  1  empty && !tx_busy (all data shifted out or handed over)
tx_data  out  8  byte at FIFO head
tx_valid  out  1  head byte available (= !empty)
tx_busy  in  1  transmitter busy; transmitter loads tx_data when tx_valid && !tx_busy

Behaviour:
- Reset: rd_ptr = wr_ptr = 0, level = 0, overflow = 0.
  - Outputs: empty = 1, full = 0, tx_valid = 0, irq_lowwater = 1, idle = !tx_busy.
  - tx_data is don't-care; memory contents are not reset.
- Storage: array of 2^DEPTH_LOG2 x 8, write port synchronous.
  - Read is combinational from registered rd_ptr, so tx_data is stable while tx_valid and no pop occurs.
  - Pointers are DEPTH_LOG2 bits and wrap naturally from 2^DEPTH_LOG2-1 to 0.
  - level is a separate registered counter.
- Push = wr_en && !full && !flush. On push: mem[wr_ptr] <= wr_data, wr_ptr++.
- Pop = tx_valid && !tx_busy && !flush; rd_ptr++ on pop.
  - This matches the transmitter's load rule exactly.
  - Transmitter busy rises the cycle after its load, so no byte is popped twice.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- Full/empty use the start-of-cycle level:
  - A write while full is dropped, even if a pop occurs the same cycle, and sets overflow.
  - A write to an empty FIFO is not visible until the next cycle (no fall-through). Write latency to tx_valid is 1 cycle.
- Overflow:
  - Set on any wr_en while full and !flush.
  - Cleared by ovf_clear.
  - ovf_clear and a new overflow event in the same cycle: the set wins.
- Flush (one cycle): rd_ptr = wr_ptr = 0, level = 0.
  - A concurrent wr_en is discarded with no overflow.
  - A concurrent pop is suppressed.
  - A byte already loaded into the transmitter completes normally; overflow is unchanged.
- Status outputs full, empty, tx_valid, irq_lowwater are pure decodes of registered level, with no combinational path from inputs.
  - Exception: idle also depends on tx_busy.
- Reset asserted mid-operation: all state returns to reset values immediately (async); buffered bytes are lost.

Decomposition:
- Shared uart package holds:
  - UART_FIFO_DEPTH_LOG2 default constant
  - LOW_WATER default constant
  - typedef for the byte type (8-bit)
- Package is shared with the transmitter and the future receiver FIFO.
- One natural sub-module: uart_fifo_mem (parameterised synchronous-write/async-read array), reusable by the RX-side FIFO.
- Pointer/level control stays in uart_tx_fifo.

Test Plan:
1. Reset, then wr_en with wr_data=0x41 for one cycle, tx_busy=0:
   - Next cycle tx_valid=1, tx_data=0x41, level=1.
   - Following cycle pop occurs; level=0, empty=1.
2. Hold tx_busy=1, write 16 bytes 0x00..0x0F:
   - full=1, level=16, irq_lowwater=0.
   - A 17th write (0xFF) sets overflow=1, level stays 16.
   - Release tx_busy in 1-cycle-low pulses: bytes emerge in order 0x00..0x0F; 0xFF never appears.
3. Fill to 16, then drain to below threshold:
   - irq_lowwater rises the cycle level becomes 4 (LOW_WATER=4).
   - ovf_clear clears overflow; ovf_clear concurrent with a write-while-full leaves overflow=1.
4. level=5 with tx_busy=0 held, pop and wr_en in the same cycle:
   - level stays 5, next head byte is correct.
   - Pointer wrap exercised by 40 continuous bytes; output order is preserved.
5. level=8, assert flush together with wr_en=1:
   - Next cycle level=0, empty=1, tx_valid=0, overflow unchanged.
   - Write 0x55: it is the next byte presented.
6. level=6, assert rst asynchronously mid-stream:
   - All outputs take reset values without a clock edge.
   - idle=1 once tx_busy=0.
